// File: rtl/cdb_arbiter_pkg.sv
// Shared types and sizing constants for the common-data-bus arbiter.
//   N_CDB_REQ    requesters sharing the bus (ALU RS 0-3, branch 4, LSQ 5)
//   N_CDB_PORTS  CDB write ports driven per cycle
//   ROB_TAG_W    ROB tag width (8-entry ROB)
//   CDB_XLEN     result data width
//   cdb_req_t    one requester/port payload {valid, tag, data}
package cdb_arbiter_pkg;

  localparam int unsigned N_CDB_REQ   = 6;
  localparam int unsigned N_CDB_PORTS = 2;
  localparam int unsigned ROB_TAG_W   = 3;
  localparam int unsigned CDB_XLEN    = 32;
  localparam int unsigned CONFLICT_W  = 16;

  typedef struct packed {
    logic                 valid;
    logic [ROB_TAG_W-1:0] tag;
    logic [CDB_XLEN-1:0]  data;
  } cdb_req_t;

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational round-robin picker: scans requesters starting at i_rr_ptr
// and assigns the first N_PORTS valid ones to ports 0..N_PORTS-1 in scan order.
//   i_req_valid    per-requester valid
//   i_rr_ptr       first index to scan (must be < N_REQ)
//   o_grant_c      per-port one-hot grant vector
//   o_port_used_c  port p received a grantee
//   o_last_idx_c   index of the last grantee in scan order
//   o_any_grant_c  at least one grant this cycle
module cdb_arbiter_rr_pick #(
  parameter int unsigned N_REQ   = 6,
  parameter int unsigned N_PORTS = 2,
  localparam int unsigned PTR_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0]                i_req_valid,
  input  logic [PTR_W-1:0]                i_rr_ptr,
  output logic [N_PORTS-1:0][N_REQ-1:0]   o_grant_c,
  output logic [N_PORTS-1:0]              o_port_used_c,
  output logic [PTR_W-1:0]                o_last_idx_c,
  output logic                            o_any_grant_c
);

  localparam int unsigned CNT_W = $clog2(N_PORTS + 1);

  logic [PTR_W:0]   w_sum;
  logic [PTR_W-1:0] w_idx;
  logic [CNT_W-1:0] w_cnt;

  // Rotating scan; w_cnt is the port the next valid requester lands on.
  always_comb begin
    o_grant_c    = '0;
    o_last_idx_c = i_rr_ptr;
    w_sum        = '0;
    w_idx        = '0;
    w_cnt        = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      // Modulo by conditional subtract: rr_ptr + k < 2*N_REQ always.
      w_sum = {1'b0, i_rr_ptr} + (PTR_W+1)'(k);
      if (w_sum >= (PTR_W+1)'(N_REQ)) begin
        w_sum = w_sum - (PTR_W+1)'(N_REQ);
      end
      w_idx = w_sum[PTR_W-1:0];
      if (i_req_valid[w_idx] && (w_cnt < CNT_W'(N_PORTS))) begin
        for (int unsigned p = 0; p < N_PORTS; p++) begin
          if (w_cnt == CNT_W'(p)) begin
            o_grant_c[p][w_idx] = 1'b1;
          end
        end
        w_cnt        = w_cnt + CNT_W'(1);
        o_last_idx_c = w_idx;
      end
    end
  end

  // Port occupancy summary.
  always_comb begin
    o_port_used_c = '0;
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      o_port_used_c[p] = |o_grant_c[p];
    end
    o_any_grant_c = |o_port_used_c;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: shares N_PORTS CDB write ports among N_REQ
// functional-unit requesters with round-robin selection and a registered,
// one-cycle-latency CDB output.
//   clk, rst       clock; asynchronous active-low reset
//   flush          branch flush: no grants, CDB emptied next edge
//   req_valid/tag/data  per-requester result (flattened slices)
//   req_ready      combinational grant, 0 in reset or flush
//   cdb_valid/tag/data  registered CDB ports
//   conflict_cnt   saturating count of oversubscribed non-flush cycles
//   err_dup_tag    sticky: two grantees carried the same tag in one cycle
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ   = N_CDB_REQ,
  parameter int unsigned N_PORTS = N_CDB_PORTS,
  parameter int unsigned TAG_W   = ROB_TAG_W,
  parameter int unsigned XLEN    = CDB_XLEN
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*TAG_W-1:0]    req_tag,
  input  logic [N_REQ*XLEN-1:0]     req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic [N_PORTS-1:0]        cdb_valid,
  output logic [N_PORTS*TAG_W-1:0]  cdb_tag,
  output logic [N_PORTS*XLEN-1:0]   cdb_data,
  output logic [CONFLICT_W-1:0]     conflict_cnt,
  output logic                      err_dup_tag
);

  localparam int unsigned PTR_W = $clog2(N_REQ);

  logic [N_PORTS-1:0][N_REQ-1:0] w_grant;
  logic [N_PORTS-1:0]            w_port_used;
  logic [PTR_W-1:0]              w_last_idx;
  logic                          w_any_grant;
  logic [N_PORTS-1:0][TAG_W-1:0] w_sel_tag;
  logic [N_PORTS-1:0][XLEN-1:0]  w_sel_data;
  logic [N_REQ-1:0]              w_ready;
  logic [PTR_W-1:0]              w_rr_ptr_nxt;
  logic                          w_oversub;
  logic                          w_dup;

  logic [N_PORTS-1:0]            r_cdb_valid;
  logic [N_PORTS-1:0][TAG_W-1:0] r_cdb_tag;
  logic [N_PORTS-1:0][XLEN-1:0]  r_cdb_data;
  logic [PTR_W-1:0]              r_rr_ptr;
  logic [CONFLICT_W-1:0]         r_conflict_cnt;
  logic                          r_err_dup_tag;

  cdb_arbiter_rr_pick #(
    .N_REQ   (N_REQ),
    .N_PORTS (N_PORTS)
  ) u_rr_pick (
    .i_req_valid   (req_valid),
    .i_rr_ptr      (r_rr_ptr),
    .o_grant_c     (w_grant),
    .o_port_used_c (w_port_used),
    .o_last_idx_c  (w_last_idx),
    .o_any_grant_c (w_any_grant)
  );

  // Grants are visible to requesters only outside reset and flush.
  always_comb begin
    w_ready = '0;
    if (rst && !flush) begin
      for (int unsigned p = 0; p < N_PORTS; p++) begin
        w_ready = w_ready | w_grant[p];
      end
    end
  end

  // One-hot port muxes.
  always_comb begin
    w_sel_tag  = '0;
    w_sel_data = '0;
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (w_grant[p][i]) begin
          w_sel_tag[p]  = req_tag[i*TAG_W +: TAG_W];
          w_sel_data[p] = req_data[i*XLEN +: XLEN];
        end
      end
    end
  end

  // Pairwise tag compare across occupied ports.
  always_comb begin
    w_dup = 1'b0;
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      for (int unsigned q = p + 1; q < N_PORTS; q++) begin
        if (w_port_used[p] && w_port_used[q] && (w_sel_tag[p] == w_sel_tag[q])) begin
          w_dup = 1'b1;
        end
      end
    end
  end

  // Next scan start is just past the last grantee, wrapping to 0.
  always_comb begin
    w_rr_ptr_nxt = w_last_idx + PTR_W'(1);
    if (w_last_idx == PTR_W'(N_REQ - 1)) begin
      w_rr_ptr_nxt = '0;
    end
    w_oversub = ($countones(req_valid) > N_PORTS);
  end

  // CDB output registers, round-robin pointer, conflict counter, sticky error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cdb_valid    <= '0;
      r_cdb_tag      <= '0;
      r_cdb_data     <= '0;
      r_rr_ptr       <= '0;
      r_conflict_cnt <= '0;
      r_err_dup_tag  <= 1'b0;
    end else if (flush) begin
      r_cdb_valid <= '0;
    end else begin
      r_cdb_valid <= w_port_used;
      for (int unsigned p = 0; p < N_PORTS; p++) begin
        if (w_port_used[p]) begin
          r_cdb_tag[p]  <= w_sel_tag[p];
          r_cdb_data[p] <= w_sel_data[p];
        end
      end
      if (w_any_grant) begin
        r_rr_ptr <= w_rr_ptr_nxt;
      end
      if (w_oversub && (r_conflict_cnt != '1)) begin
        r_conflict_cnt <= r_conflict_cnt + CONFLICT_W'(1);
      end
      if (w_dup) begin
        r_err_dup_tag <= 1'b1;
      end
    end
  end

  assign req_ready    = w_ready;
  assign cdb_valid    = r_cdb_valid;
  assign cdb_tag      = r_cdb_tag;
  assign cdb_data     = r_cdb_data;
  assign conflict_cnt = r_conflict_cnt;
  assign err_dup_tag  = r_err_dup_tag;

endmodule
